// File: rtl/coin_change_dispenser_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coin_change_dispenser_if : request, hopper and stock signals of the       |
// | change dispenser.                                     Revision: 1.0       |
// +--------------------------------------------------------------------------+
interface coin_change_dispenser_if #(
  parameter int TOTAL_BITS = 31,
  parameter int CNT_BITS   = 8
);
  logic                  i_req_valid;
  logic [TOTAL_BITS-1:0] i_req_amount;
  logic                  o_req_ready;
  logic [2:0]            i_refill;
  logic [2:0]            o_hopper_fire;
  logic                  i_hopper_ack;
  logic [2:0]            o_return_coin;
  logic                  o_done;
  logic [TOTAL_BITS-1:0] o_shortfall;
  logic [CNT_BITS-1:0]   o_stock_100;
  logic [CNT_BITS-1:0]   o_stock_500;
  logic [CNT_BITS-1:0]   o_stock_1000;

  modport master (
    output i_req_valid, i_req_amount, i_refill, i_hopper_ack,
    input  o_req_ready, o_hopper_fire, o_return_coin, o_done, o_shortfall,
    input  o_stock_100, o_stock_500, o_stock_1000
  );

  modport slave (
    input  i_req_valid, i_req_amount, i_refill, i_hopper_ack,
    output o_req_ready, o_hopper_fire, o_return_coin, o_done, o_shortfall,
    output o_stock_100, o_stock_500, o_stock_1000
  );
endinterface
`default_nettype wire

// File: rtl/coin_change_dispenser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coin_change_dispenser : pays a change amount largest-coin-first from      |
// | tracked stock, one hopper at a time.                  Revision: 1.0       |
// +--------------------------------------------------------------------------+
module coin_change_dispenser #(
  parameter int TOTAL_BITS = 31,
  parameter int CNT_BITS   = 8,
  parameter int INIT_100   = 20,
  parameter int INIT_500   = 20,
  parameter int INIT_1000  = 20,
  parameter int TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  coin_change_dispenser_if.slave bus
);

  localparam int TMO_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_BITS-1:0]   TMO_LAST  = TMO_BITS'(TIMEOUT - 1);
  localparam logic [CNT_BITS-1:0]   STOCK_MAX = '1;
  localparam logic [TOTAL_BITS-1:0] VAL_100   = TOTAL_BITS'(100);
  localparam logic [TOTAL_BITS-1:0] VAL_500   = TOTAL_BITS'(500);
  localparam logic [TOTAL_BITS-1:0] VAL_1000  = TOTAL_BITS'(1000);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                state;
  logic [TOTAL_BITS-1:0] remaining;
  logic [TOTAL_BITS-1:0] shortfall;
  logic [2:0]            jam;
  logic [2:0]            fire;
  logic [2:0]            return_coin;
  logic                  done;
  logic [TMO_BITS-1:0]   tmo_cnt;
  logic [CNT_BITS-1:0]   stock_100;
  logic [CNT_BITS-1:0]   stock_500;
  logic [CNT_BITS-1:0]   stock_1000;
  logic [2:0]            pick;
  logic [2:0]            dispensed;

  // A refill and a dispense of the same coin in one cycle cancel out.
  function automatic logic [CNT_BITS-1:0] next_stock(
    input logic [CNT_BITS-1:0] cur,
    input logic                add,
    input logic                sub
  );
    next_stock = cur;
    if (add && !sub) begin
      if (cur != STOCK_MAX) next_stock = cur + CNT_BITS'(1);
    end else if (sub && !add) begin
      next_stock = cur - CNT_BITS'(1);
    end
  endfunction

  function automatic logic [TOTAL_BITS-1:0] coin_value(input logic [2:0] onehot);
    case (onehot)
      3'b100:  coin_value = VAL_1000;
      3'b010:  coin_value = VAL_500;
      default: coin_value = VAL_100;
    endcase
  endfunction

  always_comb begin
    pick = 3'b000;
    if (remaining >= VAL_1000 && stock_1000 != '0 && !jam[2])
      pick = 3'b100;
    else if (remaining >= VAL_500 && stock_500 != '0 && !jam[1])
      pick = 3'b010;
    else if (remaining >= VAL_100 && stock_100 != '0 && !jam[0])
      pick = 3'b001;
  end

  assign dispensed = (state == WAIT_ACK && bus.i_hopper_ack) ? fire : 3'b000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      remaining   <= '0;
      shortfall   <= '0;
      jam         <= 3'b000;
      fire        <= 3'b000;
      return_coin <= 3'b000;
      done        <= 1'b0;
      tmo_cnt     <= '0;
      stock_100   <= CNT_BITS'(INIT_100);
      stock_500   <= CNT_BITS'(INIT_500);
      stock_1000  <= CNT_BITS'(INIT_1000);
    end else begin
      return_coin <= 3'b000;
      done        <= 1'b0;
      stock_100   <= next_stock(stock_100,  bus.i_refill[0], dispensed[0]);
      stock_500   <= next_stock(stock_500,  bus.i_refill[1], dispensed[1]);
      stock_1000  <= next_stock(stock_1000, bus.i_refill[2], dispensed[2]);

      case (state)
        IDLE: begin
          if (bus.i_req_valid) begin
            remaining <= bus.i_req_amount;
            jam       <= 3'b000;
            shortfall <= '0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (pick != 3'b000) begin
            fire    <= pick;
            tmo_cnt <= '0;
            state   <= WAIT_ACK;
          end else begin
            done      <= 1'b1;
            shortfall <= remaining;
            state     <= DONE;
          end
        end
        WAIT_ACK: begin
          if (bus.i_hopper_ack) begin
            remaining   <= remaining - coin_value(fire);
            return_coin <= fire;
            fire        <= 3'b000;
            state       <= SELECT;
          end else if (tmo_cnt == TMO_LAST) begin
            // Jammed hopper: skip this denomination for the rest of the request.
            jam   <= jam | fire;
            fire  <= 3'b000;
            state <= SELECT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_BITS'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req_ready   = (state == IDLE);
  assign bus.o_hopper_fire = fire;
  assign bus.o_return_coin = return_coin;
  assign bus.o_done        = done;
  assign bus.o_shortfall   = shortfall;
  assign bus.o_stock_100   = stock_100;
  assign bus.o_stock_500   = stock_500;
  assign bus.o_stock_1000  = stock_1000;

endmodule
`default_nettype wire
